// File: rtl/ps2_send_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
package ps2_send_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Full frame on the wire: start, 8 data, parity, stop.
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  // Falling edge on which the device's ACK is sampled.
  localparam int ACK_EDGE   = 11;
  // The start bit is driven in REQ, so only the rest of the frame is shifted.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  // Shift-register image sent LSB first: data, odd parity, stop.
  function automatic logic [SHIFT_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_send_negedge_det.sv
// Synchronizes the raw PS/2 clock and flags its falling edge for one cycle.
module ps2_send_negedge_det (
  input  logic clk,
  input  logic i_sclr,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall_en
);

  logic [2:0] sync_q;

  // Two synchronizer stages plus one history stage; idle line is pulled up.
  always_ff @(posedge clk) begin
    if (i_sclr) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], i_line};
  end

  assign o_sync    = sync_q[1];
  assign o_fall_en = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_send.sv
// PS/2 host-to-device command transmitter driving open-drain enables.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | lines released, waiting for a byte request
// INHIBIT    | host holds the PS/2 clock low
// REQ        | clock and data both low for one cycle (request-to-send)
// SEND       | device clocks; data, parity and stop change on each fall
// ACK        | sample the device ACK on the next falling edge
// WAIT_IDLE  | wait for both lines high, then report done
module ps2_send #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_done,
  output logic       o_err
);

  import ps2_send_pkg::*;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INHIBIT_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  // Edge count already seen when the stop-bit edge arrives.
  localparam logic [3:0]    LAST_SEND_EDGE = 4'(ACK_EDGE - 2);

  state_t                  state_q, state_d;
  logic [SHIFT_BITS-1:0]   frame_q, frame_d;
  logic [IW-1:0]           icnt_q, icnt_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [3:0]              ecnt_q, ecnt_d;
  logic                    dat_oe_q, dat_oe_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [1:0]              dat_sync_q;
  logic                    clk_sync;
  logic                    fall_en;
  logic                    dat_sync;

  ps2_send_negedge_det u_clk_det (
    .clk      (clk),
    .i_sclr   (i_sclr),
    .i_line   (i_ps2_clk),
    .o_sync   (clk_sync),
    .o_fall_en(fall_en)
  );

  // Two-stage synchronizer for the PS/2 data line.
  always_ff @(posedge clk) begin
    if (i_sclr) dat_sync_q <= 2'b11;
    else        dat_sync_q <= {dat_sync_q[0], i_ps2_dat};
  end

  assign dat_sync = dat_sync_q[1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      icnt_q   <= '0;
      tcnt_q   <= '0;
      ecnt_q   <= '0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      icnt_q   <= icnt_d;
      tcnt_q   <= tcnt_d;
      ecnt_q   <= ecnt_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counters and line control.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    icnt_d   = icnt_q;
    tcnt_d   = tcnt_q;
    ecnt_d   = ecnt_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_byte_en) begin
          state_d  = ST_INHIBIT;
          frame_d  = build_frame(i_byte);
          icnt_d   = INHIBIT_LOAD;
          ecnt_d   = '0;
          err_d    = 1'b0;
          dat_oe_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (icnt_q == '0) begin
          state_d  = ST_REQ;
          dat_oe_d = 1'b1;
        end else begin
          icnt_d = icnt_q - 1'b1;
        end
      end
      ST_REQ: begin
        state_d = ST_SEND;
        tcnt_d  = TIMEOUT_LOAD;
      end
      ST_SEND, ST_ACK: begin
        if (tcnt_q == '0) begin
          // Device stalled: release everything and report failure directly.
          state_d  = ST_IDLE;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
          if (fall_en) begin
            ecnt_d = ecnt_q + 1'b1;
            if (state_q == ST_SEND) begin
              dat_oe_d = ~frame_q[0];
              frame_d  = frame_q >> 1;
              if (ecnt_q == LAST_SEND_EDGE) state_d = ST_ACK;
            end else begin
              err_d   = dat_sync;
              state_d = ST_WAIT_IDLE;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign o_ps2_dat_oe = dat_oe_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_ps2_send.sv
// Bench for ps2_send: table of command bytes, random bytes against a
// parity/frame model, plus timeout and mid-frame reset sequences.
module tb_ps2_send;

  localparam int INH  = 8;
  localparam int TMO  = 400;
  localparam int HALF = 10;

  typedef struct {
    logic [7:0] b;
    bit         ack;
    bit         poke;
    logic       exp_par;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic i_sclr = 1'b1;
  logic i_byte_en = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic o_busy, o_ps2_clk_oe, o_ps2_dat_oe, o_done, o_err;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_line, ps2_dat_line;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;
  vec_t tbl[5];

  assign ps2_clk_line = ~(o_ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(o_ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_send #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .i_sclr      (i_sclr),
    .i_ps2_clk   (ps2_clk_line),
    .i_ps2_dat   (ps2_dat_line),
    .i_byte_en   (i_byte_en),
    .i_byte      (i_byte),
    .o_busy      (o_busy),
    .o_ps2_clk_oe(o_ps2_clk_oe),
    .o_ps2_dat_oe(o_ps2_dat_oe),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always @(negedge clk) begin
    if (o_done) begin
      done_cnt++;
      last_err = o_err;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: what the device must see on the wire for a byte.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  // Device: 11 clock pulses, samples data mid-high phase, optional ACK.
  task automatic dev_frame(input bit ack, input bit poke, output logic [10:0] cap);
    cap = '0;
    repeat (HALF - 1) @(negedge clk);
    if (poke) begin
      i_byte    = 8'h55;
      i_byte_en = 1'b1;
    end
    @(negedge clk);
    i_byte_en = 1'b0;
    cap[0] = ps2_dat_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k == 11) begin
        dev_dat_low = 1'b0;
      end else begin
        repeat (HALF / 2) @(negedge clk);
        cap[k] = ps2_dat_line;
        if (k == 10) dev_dat_low = ack;
        repeat (HALF / 2) @(negedge clk);
      end
    end
  endtask

  task automatic start_byte(input logic [7:0] b);
    @(negedge clk);
    i_byte    = b;
    i_byte_en = 1'b1;
    @(negedge clk);
    i_byte_en = 1'b0;
    i_byte    = 8'h00;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                           input bit poke, input logic [10:0] exp_frame, input logic exp_err);
    int n;
    int d0;
    logic [10:0] cap;
    d0 = done_cnt;
    start_byte(b);
    chk({tag, " busy"}, int'(o_busy), 1);
    chk({tag, " err_clr"}, int'(o_err), 0);
    n = 0;
    while (o_ps2_clk_oe === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " clk_low_len"}, n, INH + 1);
    dev_frame(ack, poke, cap);
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk({tag, " frame"}, int'(cap), int'(exp_frame));
    chk({tag, " done_once"}, done_cnt - d0, 1);
    chk({tag, " err"}, int'(last_err), int'(exp_err));
    chk({tag, " err_hold"}, int'(o_err), int'(exp_err));
    chk({tag, " idle"}, int'({o_ps2_clk_oe, o_ps2_dat_oe, o_busy}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int m;
    int d0;
    logic [7:0] rb;
    bit rack;

    tbl[0] = '{b: 8'hED, ack: 1'b1, poke: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
    tbl[1] = '{b: 8'h01, ack: 1'b1, poke: 1'b1, exp_par: 1'b0, exp_err: 1'b0};
    tbl[2] = '{b: 8'hFF, ack: 1'b1, poke: 1'b1, exp_par: 1'b1, exp_err: 1'b0};
    tbl[3] = '{b: 8'hA5, ack: 1'b0, poke: 1'b0, exp_par: 1'b1, exp_err: 1'b1};
    tbl[4] = '{b: 8'h80, ack: 1'b1, poke: 1'b0, exp_par: 1'b0, exp_err: 1'b0};

    // Reset, then 50 idle cycles with nothing driven.
    repeat (3) @(negedge clk);
    i_sclr = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_err} !== 5'b0) bad++;
    end
    chk("reset_idle", bad, 0);

    // Table of command bytes; 0x01/0xFF go back-to-back with mid-frame pokes.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].ack, tbl[i].poke,
                {1'b1, tbl[i].exp_par, tbl[i].b, 1'b0}, tbl[i].exp_err);
    end
    chk("tbl_done_total", done_cnt - d0, 5);

    // Random bytes against the frame model.
    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d_%02h", i, rb), rb, rack, 1'b0, model_frame(rb), !rack);
    end

    // Device never clocks: timeout counted from clock release.
    d0 = done_cnt;
    start_byte(8'h3C);
    n = 0;
    while (o_ps2_clk_oe === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    m = 0;
    while (o_done !== 1'b1 && m < 1000) begin
      @(negedge clk);
      m++;
    end
    chk("tmo_cycles", m, TMO);
    chk("tmo_err", int'(o_err), 1);
    chk("tmo_lines", int'({o_ps2_clk_oe, o_ps2_dat_oe, o_busy}), 0);
    repeat (3) @(negedge clk);
    chk("tmo_done_once", done_cnt - d0, 1);

    // Reset after the fifth falling edge abandons the frame.
    d0 = done_cnt;
    start_byte(8'h5A);
    n = 0;
    while (o_ps2_clk_oe === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    i_sclr = 1'b1;
    @(negedge clk);
    chk("sclr_release", int'({o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done}), 0);
    i_sclr = 1'b0;
    dev_clk_low = 1'b0;
    repeat (50) @(negedge clk);
    chk("sclr_no_done", done_cnt - d0, 0);
    run_frame("after_sclr", 8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
